// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared types and constants for the memory responder
package mem_resp_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_resp_state_t;
    localparam int MAX_LATENCY = 15;
    localparam int WCNT_W = 4;
endpackage

// File: rtl/mem_resp_array.sv
// mem_resp_array: single-port synchronous RAM with registered read and unreset storage
module mem_resp_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;
    // write on enable, read-before-write into the output register every cycle
    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        rdata_q <= mem_q[addr_i];
    end
    assign rdata_o = rdata_q;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: wait-state memory slave with transaction counters and protocol checker
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int LATENCY = 2,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mem_req,
    input  logic               mem_we,
    input  logic [ADDR_W-1:0]  mem_addr,
    input  logic [DATA_W-1:0]  mem_wdata,
    output logic [DATA_W-1:0]  mem_rdata,
    output logic               mem_ready,
    output logic               busy,
    output logic [COUNT_W-1:0] rd_count,
    output logic [COUNT_W-1:0] wr_count,
    output logic               proto_err
);
    if (LATENCY < 0 || LATENCY > MAX_LATENCY) begin : g_lat_chk
        $error("mem_responder: LATENCY must be within 0..15");
    end

    mem_resp_state_t    state_q, state_d;
    logic [WCNT_W-1:0]  cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [COUNT_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic               err_q, err_d;
    logic [DATA_W-1:0]  arr_rdata;
    logic               accept;

    assign accept = (state_q == IDLE) && mem_req;

    // next-state: accept/latch, count wait states, complete and count; flag any request disturbance
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (mem_req) begin
                we_d    = mem_we;
                addr_d  = mem_addr;
                wdata_d = mem_wdata;
                cnt_d   = WCNT_W'(LATENCY);
                state_d = (LATENCY == 0) ? RESP : WAIT;
            end
            WAIT: begin
                cnt_d   = cnt_q - WCNT_W'(1);
                state_d = (cnt_q == WCNT_W'(1)) ? RESP : WAIT;
            end
            RESP: begin
                state_d = IDLE;
                if (we_q) wr_d = wr_q + COUNT_W'(wr_q != '1);
                else      rd_d = rd_q + COUNT_W'(rd_q != '1);
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && (!mem_req || mem_we != we_q || mem_addr != addr_q || mem_wdata != wdata_q))
            err_d = 1'b1;
    end

    // state and datapath registers; reset aborts any transaction in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
        end
    end

    mem_resp_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_array (
        .clk     (clk),
        .we_i    (rst_n && accept && mem_we),
        .addr_i  ((state_q == IDLE) ? mem_addr : addr_q),
        .wdata_i (mem_wdata),
        .rdata_o (arr_rdata)
    );

    assign mem_ready = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign mem_rdata = (mem_ready && !we_q) ? arr_rdata : '0;
    assign rd_count  = rd_q;
    assign wr_count  = wr_q;
    assign proto_err = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed and random checks of three responder configurations against a reference model
module tb_mem_responder;
    logic       clk = 1'b0;
    logic       rst_n [3];
    logic       req [3];
    logic       we [3];
    logic [7:0] addr [3];
    logic [7:0] wdata [3];
    logic [7:0] rdata [3];
    logic       ready [3];
    logic       busy [3];
    logic       perr [3];
    logic [15:0] rdc0, wrc0, rdc1, wrc1;
    logic [3:0]  rdc2, wrc2;

    int n = 0;
    int fails = 0;

    logic [7:0] mm [3][256];
    bit         mvalid [3][256];
    int         mrd [3];
    int         mwr [3];
    bit         merr [3];
    int         lat [3] = '{2, 0, 1};
    int         cmax [3] = '{65535, 65535, 15};

    always #5 clk = ~clk;

    mem_responder #(.LATENCY(2), .COUNT_W(16)) u0 (
        .clk(clk), .rst_n(rst_n[0]), .mem_req(req[0]), .mem_we(we[0]), .mem_addr(addr[0]),
        .mem_wdata(wdata[0]), .mem_rdata(rdata[0]), .mem_ready(ready[0]), .busy(busy[0]),
        .rd_count(rdc0), .wr_count(wrc0), .proto_err(perr[0]));
    mem_responder #(.LATENCY(0), .COUNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n[1]), .mem_req(req[1]), .mem_we(we[1]), .mem_addr(addr[1]),
        .mem_wdata(wdata[1]), .mem_rdata(rdata[1]), .mem_ready(ready[1]), .busy(busy[1]),
        .rd_count(rdc1), .wr_count(wrc1), .proto_err(perr[1]));
    mem_responder #(.LATENCY(1), .COUNT_W(4)) u2 (
        .clk(clk), .rst_n(rst_n[2]), .mem_req(req[2]), .mem_we(we[2]), .mem_addr(addr[2]),
        .mem_wdata(wdata[2]), .mem_rdata(rdata[2]), .mem_ready(ready[2]), .busy(busy[2]),
        .rd_count(rdc2), .wr_count(wrc2), .proto_err(perr[2]));

    function automatic logic [15:0] get_rd(input int k);
        return (k == 0) ? rdc0 : (k == 1) ? rdc1 : {12'b0, rdc2};
    endfunction

    function automatic logic [15:0] get_wr(input int k);
        return (k == 0) ? wrc0 : (k == 1) ? wrc1 : {12'b0, wrc2};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input int k);
        chk("rd_count", 32'(get_rd(k)), mrd[k]);
        chk("wr_count", 32'(get_wr(k)), mwr[k]);
        chk("proto_err", 32'(perr[k]), 32'(merr[k]));
    endtask

    task automatic chk_reset_vals(input int k);
        chk("rst_ready", 32'(ready[k]), 0);
        chk("rst_busy", 32'(busy[k]), 0);
        chk("rst_rdata", 32'(rdata[k]), 0);
        chk_status(k);
    endtask

    task automatic do_reset(input int k);
        rst_n[k] = 1'b0;
        req[k] = 1'b0;
        @(negedge clk);
        rst_n[k] = 1'b1;
        mrd[k] = 0;
        mwr[k] = 0;
        merr[k] = 1'b0;
        chk_reset_vals(k);
    endtask

    // mode 0: clean; 1: change address after acceptance; 2: withdraw request after acceptance
    task automatic txn(input int k, input bit w, input logic [7:0] a, input logic [7:0] d, input int mode);
        int c;
        bit seen;
        logic [7:0] exp_rd;
        bit chk_rd;
        exp_rd = mm[k][a];
        chk_rd = w || mvalid[k][a];
        req[k] = 1'b1;
        we[k] = w;
        addr[k] = a;
        wdata[k] = d;
        @(posedge clk);
        seen = 1'b0;
        for (c = 1; c <= 20; c++) begin
            @(negedge clk);
            chk("busy", 32'(busy[k]), 1);
            if (ready[k]) begin
                seen = 1'b1;
                break;
            end
            if (c == 1 && mode == 1) begin
                addr[k] = a + 8'd1;
                merr[k] = 1'b1;
            end
            if (c == 1 && mode == 2) begin
                req[k] = 1'b0;
                merr[k] = 1'b1;
            end
        end
        chk("latency", seen ? c : 99, lat[k] + 1);
        if (chk_rd) chk("rdata", 32'(rdata[k]), w ? 0 : 32'(exp_rd));
        if (w) begin
            mm[k][a] = d;
            mvalid[k][a] = 1'b1;
            mwr[k] = (mwr[k] < cmax[k]) ? mwr[k] + 1 : mwr[k];
        end else
            mrd[k] = (mrd[k] < cmax[k]) ? mrd[k] + 1 : mrd[k];
        @(negedge clk);
        req[k] = 1'b0;
        chk("ready_pulse", 32'(ready[k]), 0);
        chk("busy_end", 32'(busy[k]), 0);
        chk_status(k);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0;
            req[k] = 1'b0;
            we[k] = 1'b0;
            addr[k] = '0;
            wdata[k] = '0;
            mrd[k] = 0;
            mwr[k] = 0;
            merr[k] = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
        for (int k = 0; k < 3; k++) chk_reset_vals(k);

        txn(0, 1'b1, 8'h10, 8'hA5, 0);
        txn(0, 1'b0, 8'h10, 8'h00, 0);

        txn(1, 1'b1, 8'hFD, 8'h11, 0);
        txn(1, 1'b1, 8'hFE, 8'h22, 0);
        txn(1, 1'b1, 8'hFF, 8'h33, 0);
        txn(1, 1'b0, 8'hFD, 8'h00, 0);
        txn(1, 1'b0, 8'hFE, 8'h00, 0);
        txn(1, 1'b0, 8'hFF, 8'h00, 0);

        txn(0, 1'b1, 8'h20, 8'h3C, 0);
        txn(0, 1'b1, 8'h21, 8'hC3, 0);
        txn(0, 1'b0, 8'h20, 8'h00, 1);
        txn(0, 1'b0, 8'h21, 8'h00, 0);
        do_reset(0);
        txn(0, 1'b0, 8'h20, 8'h00, 2);
        do_reset(0);

        txn(0, 1'b1, 8'h40, 8'h5A, 0);
        req[0] = 1'b1;
        we[0] = 1'b0;
        addr[0] = 8'h40;
        @(posedge clk);
        @(negedge clk);
        rst_n[0] = 1'b0;
        req[0] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b1;
        mrd[0] = 0;
        mwr[0] = 0;
        merr[0] = 1'b0;
        chk_reset_vals(0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_ready_after_rst", 32'(ready[0]), 0);
        end
        txn(0, 1'b0, 8'h40, 8'h00, 0);

        for (int i = 0; i < 40; i++)
            txn(int'($urandom_range(0, 1)), 1'($urandom), 8'(8'hF0 + $urandom_range(0, 15)), 8'($urandom), 0);

        for (int i = 0; i < 17; i++) txn(2, 1'b0, 8'h00, 8'h00, 0);
        chk("sat_rd", 32'(rdc2), 15);
        chk("sat_wr", 32'(wrc2), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
        $finish;
    end
endmodule
